serial_add_ctrl: RTL

//  Bit-serial add sequencer built around one full_adder cell (ports a,b,c,sum,carry).
//  - Latches two WIDTH-bit operands on a start request.
//  - Feeds them LSB-first through the cell, one bit per clock, holding the carry in a flip-flop.
//  - Returns the WIDTH-bit sum and carry-out with a busy/done handshake.
//  - Trades latency for area wherever a multi-bit adder is shared or too costly.

---
 rtl/serial_add_ctrl_if.sv | 35 +++
 rtl/serial_add_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bus for the bit-serial add sequencer.
// The master drives the request and operands, the slave (serial_add_ctrl)
// returns busy/done and the held result. Optional macro: SERIAL_ADD_SUB_EN
// adds the 'sub' request bit.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell processes the operands LSB-first,
// one bit per clock, with the carry held in a flip-flop between bits.
// FSM IDLE -> RUN (WIDTH cycles) -> DONE (one-cycle done pulse) -> IDLE.
// Optional macro: SERIAL_ADD_SUB_EN adds a 'sub' request that computes
// a - b by latching ~b and forcing the initial carry to 1.

// Single-bit full adder cell shared by every bit position.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    // The bit counter needs at least one bit even when WIDTH == 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
    assign b_load     = bus.sub ? ~bus.b_in : bus.b_in;
    assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load     = bus.b_in;
    assign carry_load = bus.cin;
`endif

    // Result register after this bit: shift right, new sum bit enters at the MSB.
    always_comb begin
        s_next            = s_sh >> 1;
        s_next[WIDTH-1]   = fa_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and handshake outputs (busy/done are pure state decodes,
    // so they can never be high together).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and infers a latch.
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                bus.busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand shift registers, carry flop, bit counter and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are plain flops, not a memory, so they
            // are cleared with the rest; an aborted operation leaves no residue.
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a_in;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_q  <= s_next;
                        cout_q <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum_out = sum_q;
    assign bus.cout    = cout_q;
endmodule
